// File: rtl/bram_fifo_pkg.sv
// Shared types and constants for the BRAM-backed FIFO controller.
package bram_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int OVF_CNT_W  = 16;
  localparam int SKID_DEPTH = 2;

  // Width of a counter able to hold every word the controller can own.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + SKID_DEPTH) + 1;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Valid/ready word stream used on both sides of the BRAM FIFO controller.
interface bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 678
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_out_skid.sv
// Two-entry output skid that absorbs the BRAM read latency; head is the
// word currently presented downstream, tail holds the overflow word.
module fifo_out_skid
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 678
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            skid_cnt
);

  skid_state_e           state_reg, state_next;
  logic [DATA_WIDTH-1:0] head_reg, tail_reg;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) state_reg <= EMPTY;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (capture) state_next = ONE;
      ONE: begin
        if (capture && !pop)      state_next = TWO;
        else if (!capture && pop) state_next = EMPTY;
      end
      TWO:     if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    valid    = 1'b0;
    skid_cnt = 2'd0;
    case (state_reg)
      ONE: begin
        valid    = 1'b1;
        skid_cnt = 2'd1;
      end
      TWO: begin
        valid    = 1'b1;
        skid_cnt = 2'd2;
      end
      default: ;
    endcase
  end

  // With one entry held, a capture alongside a pop replaces head directly.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: if (capture) head_reg <= data;
        ONE: begin
          if (capture && pop) head_reg <= data;
          else if (capture)   tail_reg <= data;
        end
        TWO:     if (pop) head_reg <= tail_reg;
        default: ;
      endcase
    end
  end

  assign head = head_reg;

  a_no_capture_when_full: assert property (
    @(posedge clka) disable iff (!rsta_n) !(state_reg == TWO && capture));

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external simple-dual-port BRAM.
// Optional statistics (max_occ, ovf_cnt) are built when FIFO_CTRL_STATS_EN is defined.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 678,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  bram_fifo_ctrl_if.slave       s,
  bram_fifo_ctrl_if.master      m,
  output logic [ADDR_W-1:0]     bram_addra,
  output logic                  bram_wea,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic [ADDR_W-1:0]     bram_addrb,
  output logic                  bram_enb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      max_occ,
  output logic [OVF_CNT_W-1:0]  ovf_cnt
);

  localparam int OCC_W = ADDR_W + 1;

  logic [ADDR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]      bram_occ_reg, bram_occ_next;
  logic                  rd_pending_reg;
  logic                  s_ready_int;
  logic                  push, issue, m_fire;
  logic                  skid_valid;
  logic [1:0]            skid_cnt;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [2:0]            in_flight;

  assign s_ready_int = (bram_occ_reg < OCC_W'(DEPTH));
  assign push        = s.valid & s_ready_int;
  assign m_fire      = skid_valid & m.ready;

  // Reads are only issued when the skid is guaranteed room for the result.
  assign in_flight = {1'b0, skid_cnt} + {2'b00, rd_pending_reg};
  assign issue     = (bram_occ_reg != '0) && (in_flight < (3'd2 + {2'b00, m_fire}));

  always_comb begin
    bram_occ_next = bram_occ_reg;
    case ({push, issue})
      2'b10:   bram_occ_next = bram_occ_reg + OCC_W'(1);
      2'b01:   bram_occ_next = bram_occ_reg - OCC_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      bram_occ_reg   <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (issue) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      bram_occ_reg   <= bram_occ_next;
      rd_pending_reg <= issue;
    end
  end

  fifo_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clka     (clka),
    .rsta_n   (rsta_n),
    .capture  (rd_pending_reg),
    .data     (bram_doutb),
    .pop      (m_fire),
    .valid    (skid_valid),
    .head     (skid_head),
    .skid_cnt (skid_cnt)
  );

  assign s.ready    = s_ready_int;
  assign m.valid    = skid_valid;
  assign m.data     = skid_head;
  assign bram_addra = wr_ptr_reg;
  assign bram_wea   = push;
  assign bram_dina  = s.data;
  assign bram_addrb = rd_ptr_reg;
  assign bram_enb   = issue;
  assign count      = CNT_W'(bram_occ_reg) + CNT_W'(rd_pending_reg) + CNT_W'(skid_cnt);

`ifdef FIFO_CTRL_STATS_EN
  logic [CNT_W-1:0]     max_occ_reg;
  logic [OVF_CNT_W-1:0] ovf_cnt_reg;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      max_occ_reg <= '0;
      ovf_cnt_reg <= '0;
    end else begin
      if (count > max_occ_reg) max_occ_reg <= count;
      if (s.valid && !s_ready_int && ovf_cnt_reg != '1)
        ovf_cnt_reg <= ovf_cnt_reg + OVF_CNT_W'(1);
    end
  end

  assign max_occ = max_occ_reg;
  assign ovf_cnt = ovf_cnt_reg;
`else
  assign max_occ = '0;
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural BRAM beside it.
module tb_bram_fifo_ctrl;
  import bram_fifo_pkg::*;

  localparam int DW     = 678;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 2) + 1;
  localparam int RW     = ((DW + 31) / 32) * 32;
`ifdef FIFO_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rsta_n = 1'b0;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) s_bus ();
  bram_fifo_ctrl_if #(.DATA_WIDTH(DW)) m_bus ();

  logic [AW-1:0]        bram_addra, bram_addrb;
  logic                 bram_wea, bram_enb;
  logic [DW-1:0]        bram_dina, bram_doutb;
  logic [CW-1:0]        count, max_occ;
  logic [OVF_CNT_W-1:0] ovf_cnt;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clka       (clk),
    .rsta_n     (rsta_n),
    .s          (s_bus),
    .m          (m_bus),
    .bram_addra (bram_addra),
    .bram_wea   (bram_wea),
    .bram_dina  (bram_dina),
    .bram_addrb (bram_addrb),
    .bram_enb   (bram_enb),
    .bram_doutb (bram_doutb),
    .count      (count),
    .max_occ    (max_occ),
    .ovf_cnt    (ovf_cnt)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [RW-1:0] t;
    for (int i = 0; i < RW / 32; i++) t[i*32 +: 32] = $urandom();
    return t[DW-1:0];
  endfunction

  // Reference model: an ordered queue of accepted words and a held-word count.
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (!rsta_n) begin
      exp_q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
    end else begin
      chk("count_model", 64'(count), 64'(model_cnt));
      if (stall_prev && m_bus.valid) chk_data("m_data_stable", m_bus.data, held_data);
      if (s_bus.valid && s_bus.ready) begin
        exp_q.push_back(s_bus.data);
        model_cnt++;
      end
      if (m_bus.valid && m_bus.ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'(1), 64'(0));
        end else begin
          exp_w = exp_q.pop_front();
          chk_data("pop_data", m_bus.data, exp_w);
          $display("pop  data[31:0]=%h  queued=%0d", m_bus.data[31:0], exp_q.size());
        end
        model_cnt--;
      end
      stall_prev = m_bus.valid && !m_bus.ready;
      held_data  = m_bus.data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rsta_n      = 1'b0;
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b0;
    repeat (2) tick();
    rsta_n = 1'b1;
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    n = 0;
    while (count != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(count), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, outs, wraps;
    logic [DW-1:0] w;
    s_bus.valid = 1'b0;
    s_bus.data  = '0;
    m_bus.ready = 1'b0;
    rsta_n      = 1'b0;
    repeat (2) tick();
    chk("rst_m_valid", 64'(m_bus.valid), 64'(0));
    chk("rst_s_ready", 64'(s_bus.ready), 64'(1));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_wea", 64'(bram_wea), 64'(0));
    chk("rst_enb", 64'(bram_enb), 64'(0));
    chk("rst_max_occ", 64'(max_occ), 64'(0));
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
    rsta_n = 1'b1;
    tick();

    // Single word latency: accept in cycle 0, m_valid in cycle 3.
    m_bus.ready = 1'b1;
    w = '0;
    w[7:0] = 8'hA5;
    s_bus.data  = w;
    s_bus.valid = 1'b1;
    tick();
    s_bus.valid = 1'b0;
    chk("lat_c1_enb", 64'(bram_enb), 64'(1));
    chk("lat_c1_m_valid", 64'(m_bus.valid), 64'(0));
    tick();
    chk("lat_c2_m_valid", 64'(m_bus.valid), 64'(0));
    tick();
    chk("lat_c3_m_valid", 64'(m_bus.valid), 64'(1));
    chk_data("lat_c3_m_data", m_bus.data, w);
    tick();
    chk("lat_c4_m_valid", 64'(m_bus.valid), 64'(0));
    chk("lat_c4_count", 64'(count), 64'(0));

    // Fill with downstream stalled: DEPTH + 2 words fit.
    m_bus.ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_bus.valid = 1'b1;
      s_bus.data  = rand_word();
      #1;
      if (s_bus.ready) acc++;
      tick();
    end
    chk("fill_accepted", 64'(acc), 64'(DEPTH + 2));
    chk("fill_s_ready", 64'(s_bus.ready), 64'(0));
    chk("fill_count", 64'(count), 64'(DEPTH + 2));
    chk("fill_ovf_cnt", 64'(ovf_cnt), STATS ? 64'(2) : 64'(0));
    chk("fill_max_occ", 64'(max_occ), STATS ? 64'(DEPTH + 2) : 64'(0));

    // Full: pop and push offered together; the push waits one cycle.
    s_bus.data  = rand_word();
    m_bus.ready = 1'b1;
    #1;
    chk("full_push_blocked", 64'(s_bus.ready), 64'(0));
    tick();
    chk("push_after_pop", 64'(s_bus.ready), 64'(1));
    tick();
    drain(60);

    // Streaming from reset: 100 words at one per cycle.
    do_reset();
    m_bus.ready = 1'b1;
    acc = 0;
    outs = 0;
    wraps = 0;
    for (int cyc = 0; cyc < 103; cyc++) begin
      s_bus.valid = (cyc < 100);
      s_bus.data  = rand_word();
      #1;
      if (s_bus.valid && s_bus.ready) acc++;
      if (bram_wea && bram_addra == AW'(DEPTH - 1)) wraps++;
      if (cyc >= 3 && m_bus.valid) outs++;
      tick();
    end
    chk("stream_accepted", 64'(acc), 64'(100));
    chk("stream_outputs", 64'(outs), 64'(100));
    chk("stream_wr_wraps", 64'(wraps), 64'(6));
    chk("stream_count", 64'(count), 64'(0));

    // Random traffic with a 50 % downstream stall rate.
    for (int cyc = 0; cyc < 600; cyc++) begin
      s_bus.valid = ($urandom_range(0, 99) < 60);
      s_bus.data  = rand_word();
      m_bus.ready = $urandom_range(0, 1) == 1;
      tick();
    end
    drain(60);

    // Reset with words queued, then the next push is the first word out.
    m_bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_bus.valid = 1'b1;
      s_bus.data  = rand_word();
      tick();
    end
    s_bus.valid = 1'b0;
    repeat (4) tick();
    chk("mid_queued", 64'(count), 64'(5));
    rsta_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_bus.valid), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_s_ready", 64'(s_bus.ready), 64'(1));
    tick();
    rsta_n = 1'b1;
    tick();
    w = rand_word();
    m_bus.ready = 1'b1;
    s_bus.data  = w;
    s_bus.valid = 1'b1;
    tick();
    s_bus.valid = 1'b0;
    acc = 0;
    while (!m_bus.valid && acc < 10) begin
      tick();
      acc++;
    end
    chk("mid_first_valid", 64'(m_bus.valid), 64'(1));
    chk_data("mid_first_word", m_bus.data, w);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
